// File: rtl/audio_in_recorder.sv
// rtl/audio_in_recorder.sv - ADC FIFO drain, L/R mono mix and sequential RAM capture
// Every available pair is popped; only pairs seen in ARM/RECORD may be stored.

module audio_in_recorder #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 10001,
  parameter int DECIM  = 1,
  parameter int SHIFT  = 14,
  parameter int THRESH = 0
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  input  logic              audio_in_available,
  input  logic [31:0]       left_channel_audio_in,
  input  logic [31:0]       right_channel_audio_in,
  output logic              read_audio_in,
  output logic [ADDR_W-1:0] mem_address,
  output logic [15:0]       mem_data,
  output logic              mem_wren,
  output logic              recording,
  output logic              done,
  output logic [ADDR_W-1:0] sample_count
);

  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DW-1:0]     LP_DEC_LAST  = DW'(DECIM - 1);
  localparam logic [ADDR_W-1:0] LP_LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [17:0]       LP_THRESH    = 18'(THRESH);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RECORD, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [DW-1:0]       r_dec_cnt;
  logic                r_mem_wren;
  logic [ADDR_W-1:0]   r_mem_address;
  logic [15:0]         r_mem_data;

  logic signed [31:0]  w_mono32;
  logic [15:0]         w_mono16;
  logic [16:0]         w_ext;
  logic [16:0]         w_mag17;
  logic                w_trig;
  logic                w_last;
  logic                w_store;
  logic                w_clear;
  logic [DW-1:0]       w_dec_src;
  logic [DW-1:0]       w_dec_wrap;
  logic [DW-1:0]       w_dec_next;

  assign read_audio_in = audio_in_available;

  assign w_mono32 = ($signed(left_channel_audio_in) >>> 1) + ($signed(right_channel_audio_in) >>> 1);
  assign w_mono16 = 16'(w_mono32 >>> SHIFT);

  // 17-bit magnitude so that -32768 yields +32768 rather than wrapping
  assign w_ext   = {w_mono16[15], w_mono16};
  assign w_mag17 = w_mono16[15] ? (~w_ext + 17'd1) : w_ext;
  assign w_trig  = ({1'b0, w_mag17} + 18'd1) > LP_THRESH;

  assign w_last     = (r_wr_ptr == LP_LAST_ADDR);
  assign w_dec_src  = (r_state == S_ARM) ? '0 : r_dec_cnt;
  assign w_dec_wrap = (w_dec_src == LP_DEC_LAST) ? '0 : w_dec_src + DW'(1);

  always_comb begin
    w_next     = r_state;
    w_store    = 1'b0;
    w_clear    = 1'b0;
    w_dec_next = r_dec_cnt;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start && !stop) begin
          w_next  = S_ARM;
          w_clear = 1'b1;
        end
      end
      S_ARM: begin
        if (stop) begin
          w_next = S_IDLE;
        end else if (audio_in_available && w_trig) begin
          w_store    = 1'b1;
          w_dec_next = w_dec_wrap;
          w_next     = w_last ? S_DONE : S_RECORD;
        end
      end
      S_RECORD: begin
        if (audio_in_available) begin
          w_store    = (r_dec_cnt == '0);
          w_dec_next = w_dec_wrap;
        end
        if (stop || (w_store && w_last)) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= '0;
      r_dec_cnt     <= '0;
      r_mem_wren    <= 1'b0;
      r_mem_address <= '0;
      r_mem_data    <= '0;
    end else begin
      r_state    <= w_next;
      r_mem_wren <= w_store;
      if (w_clear) begin
        r_wr_ptr  <= '0;
        r_dec_cnt <= '0;
      end else begin
        r_dec_cnt <= w_dec_next;
        if (w_store) begin
          r_mem_address <= r_wr_ptr;
          r_mem_data    <= w_mono16;
          r_wr_ptr      <= r_wr_ptr + ADDR_W'(1);
        end
      end
    end
  end

  assign mem_address  = r_mem_address;
  assign mem_data     = r_mem_data;
  assign mem_wren     = r_mem_wren;
  assign recording    = (r_state == S_ARM) || (r_state == S_RECORD);
  assign done         = (r_state == S_DONE);
  assign sample_count = r_wr_ptr;

endmodule
